// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader: IM size, checksum width
// and the loader state encoding.
package im_pkg;

   localparam int IM_DEPTH = 1024;
   localparam int CSUM_W   = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      LOAD = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } im_state_e;

endpackage

// File: rtl/im_loader.sv
// Byte-stream program loader: takes a length-prefixed, checksummed image over a
// valid/ready byte stream and writes each payload byte into the IM byte array.
module im_loader
   import im_pkg::*;
#(
   parameter int DEPTH  = IM_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready.
   // in_ready is decoded from the state register only, never from in_valid.

   im_state_e           state;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   offset;
   logic [31:0]         len_q;
   logic [CSUM_W-1:0]   sum;

   logic                accept;
   logic [31:0]         len_next;
   logic [ADDR_W:0]     end_addr;
   logic [CSUM_W-1:0]   sum_next;
   logic                last_byte;

   assign in_ready  = (state == LEN) || (state == LOAD) || (state == CHK);
   assign busy      = in_ready;
   assign accept    = in_valid && in_ready;
   assign len_next  = {len_q[23:0], in_data};
   assign sum_next  = sum + in_data;
   // One extra bit so base+LEN wrapping past 2^ADDR_W still fails the bound.
   assign end_addr  = {1'b0, base_q} + {1'b0, ADDR_W'(len_next)};
   assign last_byte = (offset == ADDR_W'(len_q) - ADDR_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base_q    <= '0;
         offset    <= '0;
         len_q     <= '0;
         sum       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  done <= 1'b0;
                  if (base_addr[1:0] != 2'b00) begin
                     error <= 1'b1;
                     state <= ERR;
                  end else begin
                     base_q <= base_addr;
                     sum    <= '0;
                     offset <= '0;
                     len_q  <= '0;
                     error  <= 1'b0;
                     state  <= LEN;
                  end
               end
            end
            // offset counts the length bytes here and restarts at 0 for the payload.
            LEN: begin
               if (accept) begin
                  len_q  <= len_next;
                  sum    <= sum_next;
                  offset <= offset + ADDR_W'(1);
                  if (offset == ADDR_W'(3)) begin
                     offset <= '0;
                     if ((len_next[1:0] != 2'b00) || (end_addr > (ADDR_W+1)'(DEPTH))) begin
                        error <= 1'b1;
                        state <= ERR;
                     end else if (len_next == 32'd0) begin
                        state <= CHK;
                     end else begin
                        state <= LOAD;
                     end
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= base_q + offset;
                  mem_wdata <= in_data;
                  sum       <= sum_next;
                  offset    <= offset + ADDR_W'(1);
                  if (last_byte) begin
                     state <= CHK;
                  end
               end
            end
            CHK: begin
               if (accept) begin
                  sum <= sum_next;
                  if (sum_next == '0) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     error <= 1'b1;
                     state <= ERR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream program loader; the write-side counterpart of the byte-addressed, big-endian instruction memory.
- Accepts a framed image over a valid/ready byte interface and issues one byte write per accepted payload byte into the IM byte array.
- Checks length, alignment and checksum, and reports done or error.
- Sits between the host/UART byte source and the IM write port; the CPU is held off while busy is high.

Parameters:
- DEPTH, 1024, IM size in bytes (valid byte addresses 0..DEPTH-1).
- ADDR_W, 32, width of the base and memory addresses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- base_addr  in  ADDR_W  first IM byte address; sampled when start is accepted.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_W  IM byte address to write.
- mem_wdata  out  8  IM byte write data.
- mem_we  out  1  IM byte write strobe, one cycle per byte.
- busy  out  1  high in LEN, LOAD and CHK.
- done  out  1  load completed with a good checksum; held until the next start or rst.
- error  out  1  load failed; held until the next start or rst.

Behaviour:
- Reset: state IDLE. in_ready, mem_we, busy, done and error are 0. mem_addr and mem_wdata are 0. The internal sum, length and offset registers are 0.
- Handshake: a byte transfers on any edge where in_valid and in_ready are both 1. in_ready is 1 exactly in LEN, LOAD and CHK. in_ready is a registered state decode and never depends combinationally on in_valid.
- Frame format:
  - 4 length bytes, big-endian, MSB first.
  - LEN payload bytes.
  - 1 checksum byte C, such that (sum of all 4 length bytes + all payload bytes + C) mod 256 == 0.
- IDLE/DONE/ERR on start:
  - If base_addr[1:0] != 0: go to ERR.
  - Otherwise latch base_addr, clear the sum, offset, done and error, and go to LEN.
- LEN:
  - Shift each accepted byte into the length register and add it to the sum.
  - After the 4th byte, go to ERR if LEN[1:0] != 0 or base+LEN > DEPTH.
  - Otherwise go to CHK if LEN == 0, else go to LOAD.
- LOAD:
  - Each accepted byte raises mem_we on the next cycle, with mem_addr = base+offset and mem_wdata = the byte. Write latency is 1 cycle; back-to-back bytes give back-to-back writes.
  - Increment offset and add the byte to the sum.
  - After the byte with offset == LEN-1, go to CHK.
- CHK:
  - On the accepted byte, go to DONE with done=1 if (sum + byte) mod 256 == 0.
  - Otherwise go to ERR with error=1. Bytes already written are not rolled back.
- start while busy is ignored. in_valid while not busy is ignored; in_ready is 0.
- in_valid gaps in any state stall the FSM with no timeout.
- Sum and offset arithmetic: the sum is 8-bit with wrap. Offset and address arithmetic are ADDR_W bits. The bounds check uses an ADDR_W+1 bit sum so overflow is caught.
- rst mid-load: next edge returns to IDLE and mem_we=0. No further writes occur.

Decomposition:
- Shared package im_pkg:
  - IM_DEPTH constant (1024).
  - Loader state enum: IDLE, LEN, LOAD, CHK, DONE, ERR.
  - Checksum width constant (8).
- Single module. An optional sub-module im_byte_ram (a byte array with a write port and a 4-byte big-endian read port) is used only in the bench to check writes against IM read data.

Test Plan:
- Good load: base=0x10, stream 00 00 00 08, DE AD BE EF 00 00 00 01, correct C -> 8 writes at 0x10..0x17, big-endian word read at 0x10 = 0xDEADBEEF, done=1, error=0.
- Bad checksum: same frame with C+1 -> 8 writes occur, then error=1, done=0, state ERR; next start clears error.
- Bounds and alignment: base=0x3FC with LEN=8 -> error after the 4th length byte, no mem_we. base=0x02 -> error on start, in_ready stays 0. LEN=6 -> error.
- Stalls: in_valid toggled 1/0 every cycle during LOAD of 4 bytes -> exactly 4 writes, each one cycle after its handshake, with consecutive addresses.
- Reset mid-load: rst asserted after the 2nd payload byte -> mem_we=0 from the next edge; busy=0, done=0, error=0; a subsequent clean load succeeds.
- Zero length and ignored inputs: stream 00 00 00 00, C=00 -> done=1 with no writes. A start pulse during LEN and in_valid while in IDLE have no effect.
